// File: rtl/scan_multiplexer.sv
// scan_multiplexer: N-channel, W-bit registered multiplexer with a manual
// select mode and an automatic round-robin scan mode. A one-cycle STROBE
// marks the first cycle in which CH holds a new channel index.
module scan_multiplexer #(
   parameter  int WIDTH    = 4,
   parameter  int CHANNELS = 4,
   parameter  int DWELL    = 4,
   localparam int SEL_W    = $clog2(CHANNELS)
) (
   input  logic                      CLOCK,
   input  logic                      RESET,
   input  logic [CHANNELS*WIDTH-1:0] D,
   input  logic                      MODE,
   input  logic [SEL_W-1:0]          S,
   input  logic                      HOLD,
   output logic [WIDTH-1:0]          Z,
   output logic [SEL_W-1:0]          CH,
   output logic                      STROBE
);

   // A dwell of one cycle still needs a one-bit counter so the width is legal;
   // the counter then simply stays at zero.
   localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

   localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(CHANNELS - 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

   logic [SEL_W-1:0] ch_q,  ch_next;
   logic [CNT_W-1:0] cnt_q, cnt_next;
   logic             strobe_q, strobe_next;
   logic [WIDTH-1:0] z_q;
   logic [WIDTH-1:0] sel_data;

   // Pick the data slice addressed by the current (pre-edge) channel index.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (ch_q == i[SEL_W-1:0]) begin
            sel_data = D[i*WIDTH +: WIDTH];
         end
      end
   end

   // Next channel, dwell count and strobe for manual and scan modes.
   always_comb begin
      ch_next     = ch_q;
      cnt_next    = cnt_q;
      strobe_next = 1'b0;
      if (!MODE) begin
         // Manual mode discards any partial dwell so a later scan starts fresh.
         cnt_next = '0;
         if (S <= LAST_CH) begin
            ch_next     = S;
            strobe_next = (S != ch_q);
         end
      end else if (!HOLD) begin
         if (cnt_q == LAST_CNT) begin
            cnt_next    = '0;
            ch_next     = (ch_q == LAST_CH) ? '0 : ch_q + SEL_W'(1);
            strobe_next = 1'b1;
         end else begin
            cnt_next = cnt_q + CNT_W'(1);
         end
      end
   end

   // State and output registers with synchronous active-high reset.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         ch_q     <= '0;
         cnt_q    <= '0;
         strobe_q <= 1'b0;
         z_q      <= '0;
      end else begin
         ch_q     <= ch_next;
         cnt_q    <= cnt_next;
         strobe_q <= strobe_next;
         z_q      <= sel_data;
      end
   end

   assign Z      = z_q;
   assign CH     = ch_q;
   assign STROBE = strobe_q;

endmodule

// File: tb/tb_scan_multiplexer.sv
// Bench for scan_multiplexer: a table of directed vectors for a 3-channel,
// dwell-2 instance, plus a hand-written sequence for a 5-channel, dwell-1 one.
module tb_scan_multiplexer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A: WIDTH=4, CHANNELS=3, DWELL=2
   logic        a_reset, a_mode, a_hold;
   logic [11:0] a_d;
   logic [1:0]  a_s;
   logic [3:0]  a_z;
   logic [1:0]  a_ch;
   logic        a_strobe;

   scan_multiplexer #(.WIDTH(4), .CHANNELS(3), .DWELL(2)) dut_a (
      .CLOCK (clk),
      .RESET (a_reset),
      .D     (a_d),
      .MODE  (a_mode),
      .S     (a_s),
      .HOLD  (a_hold),
      .Z     (a_z),
      .CH    (a_ch),
      .STROBE(a_strobe)
   );

   // Instance B: WIDTH=4, CHANNELS=5, DWELL=1
   logic        b_reset, b_mode, b_hold;
   logic [19:0] b_d;
   logic [2:0]  b_s;
   logic [3:0]  b_z;
   logic [2:0]  b_ch;
   logic        b_strobe;

   scan_multiplexer #(.WIDTH(4), .CHANNELS(5), .DWELL(1)) dut_b (
      .CLOCK (clk),
      .RESET (b_reset),
      .D     (b_d),
      .MODE  (b_mode),
      .S     (b_s),
      .HOLD  (b_hold),
      .Z     (b_z),
      .CH    (b_ch),
      .STROBE(b_strobe)
   );

   typedef struct {
      logic        rst;
      logic        mode;
      logic [1:0]  s;
      logic        hold;
      logic [11:0] d;
      logic [1:0]  ch;
      logic [3:0]  z;
      logic        st;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string name, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic add(input logic rst, input logic mode, input logic [1:0] s,
                      input logic hold, input logic [11:0] d, input logic [1:0] ch,
                      input logic [3:0] z, input logic st);
      vec_t v;
      v.rst = rst; v.mode = mode; v.s = s; v.hold = hold; v.d = d;
      v.ch = ch; v.z = z; v.st = st;
      vecs.push_back(v);
   endtask

   localparam logic [11:0] DCBA = 12'hCBA;

   initial begin
      a_reset = 1'b1; a_mode = 1'b1; a_hold = 1'b1; a_s = 2'd3; a_d = 12'h5F3;
      b_reset = 1'b1; b_mode = 1'b1; b_hold = 1'b0; b_s = 3'd7; b_d = 20'h54321;

      // Expected CH / Z / STROBE are the values after the edge the row is applied to.
      //  rst mode s  hold d      ch z    st
      add(1, 1, 3, 1, 12'h5F3, 0, 4'h0, 0);   // reset with garbage inputs
      add(1, 1, 3, 1, 12'h96E, 0, 4'h0, 0);
      add(0, 1, 0, 0, DCBA,    0, 4'hA, 0);   // scan: dwell 2 per channel
      add(0, 1, 0, 0, DCBA,    1, 4'hA, 1);
      add(0, 1, 0, 0, DCBA,    1, 4'hB, 0);
      add(0, 1, 0, 0, DCBA,    2, 4'hB, 1);
      add(0, 1, 0, 0, DCBA,    2, 4'hC, 0);
      add(0, 1, 0, 0, DCBA,    0, 4'hC, 1);   // wrap 2 -> 0
      add(0, 1, 0, 0, DCBA,    0, 4'hA, 0);
      add(0, 1, 0, 0, DCBA,    1, 4'hA, 1);
      add(0, 1, 0, 0, DCBA,    1, 4'hB, 0);   // CH=1, counter=1
      add(0, 1, 0, 1, DCBA,    1, 4'hB, 0);   // hold 5 edges at the wrap point
      add(0, 1, 0, 1, DCBA,    1, 4'hB, 0);
      add(0, 1, 0, 1, DCBA,    1, 4'hB, 0);
      add(0, 1, 0, 1, DCBA,    1, 4'hB, 0);
      add(0, 1, 0, 1, DCBA,    1, 4'hB, 0);
      add(0, 1, 0, 0, DCBA,    2, 4'hB, 1);   // release: advance at once
      add(1, 1, 0, 0, DCBA,    0, 4'h0, 0);   // reset mid-dwell at CH=2
      add(0, 1, 0, 0, DCBA,    0, 4'hA, 0);   // counter restarted at 0
      add(0, 1, 0, 0, DCBA,    1, 4'hA, 1);
      add(0, 0, 2, 0, DCBA,    2, 4'hB, 1);   // manual S=2
      add(0, 0, 2, 0, 12'h7E5, 2, 4'h7, 0);   // S=2 again, new data on ch 2
      add(0, 0, 0, 0, DCBA,    0, 4'hC, 1);   // S=0
      add(0, 0, 3, 0, DCBA,    0, 4'hA, 0);   // out of range: unchanged
      add(0, 0, 1, 0, DCBA,    1, 4'hA, 1);
      add(0, 0, 1, 0, DCBA,    1, 4'hB, 0);
      add(0, 1, 0, 0, DCBA,    1, 4'hB, 0);   // manual -> scan: full dwell on 1
      add(0, 1, 0, 0, DCBA,    2, 4'hB, 1);
      add(0, 1, 0, 0, DCBA,    2, 4'hC, 0);   // counter now 1
      add(0, 0, 0, 0, DCBA,    0, 4'hC, 1);   // scan -> manual mid-dwell
      add(0, 0, 1, 1, DCBA,    1, 4'hA, 1);   // HOLD ignored in manual
      add(0, 1, 0, 0, DCBA,    1, 4'hB, 0);   // manual cleared the counter
      add(0, 1, 0, 0, DCBA,    2, 4'hB, 1);

      foreach (vecs[i]) begin
         @(negedge clk);
         a_reset = vecs[i].rst; a_mode = vecs[i].mode; a_s = vecs[i].s;
         a_hold  = vecs[i].hold; a_d = vecs[i].d;
         @(posedge clk);
         #1;
         chk("a_ch",     i, 32'(a_ch),     32'(vecs[i].ch));
         chk("a_z",      i, 32'(a_z),      32'(vecs[i].z));
         chk("a_strobe", i, 32'(a_strobe), 32'(vecs[i].st));
      end

      // Instance B: 5 channels, dwell 1, D = {5,4,3,2,1}
      @(negedge clk);
      b_reset = 1'b1;
      @(posedge clk);
      #1;
      chk("b_reset_ch", 0, 32'(b_ch), 32'd0);
      chk("b_reset_z",  0, 32'(b_z),  32'd0);
      @(negedge clk);
      b_reset = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         @(posedge clk);
         #1;
         chk("b_ch",     k, 32'(b_ch),     32'(k % 5));
         chk("b_z",      k, 32'(b_z),      32'(((k - 1) % 5) + 1));
         chk("b_strobe", k, 32'(b_strobe), 32'd1);
         chk("b_ch_range", k, 32'(b_ch < 3'd5), 32'd1);
      end
      // CH is 2 here; hold one edge then release.
      @(negedge clk);
      b_hold = 1'b1;
      @(posedge clk);
      #1;
      chk("b_hold_ch",     8, 32'(b_ch),     32'd2);
      chk("b_hold_strobe", 8, 32'(b_strobe), 32'd0);
      chk("b_hold_z",      8, 32'(b_z),      32'd3);
      @(negedge clk);
      b_hold = 1'b0;
      @(posedge clk);
      #1;
      chk("b_resume_ch",     9, 32'(b_ch),     32'd3);
      chk("b_resume_strobe", 9, 32'(b_strobe), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/scan_multiplexer.md
# scan_multiplexer

Parametrised N-channel, W-bit registered multiplexer with a manual-select mode and an automatic round-robin scan mode. It supersedes the single-bit 2:1 combinational multiplexer. It is the channel-selection stage ahead of display and LED drivers that must time-share one output path among several sources. Each change of channel is signalled by a one-cycle strobe.

## Interface
- WIDTH, 4, bits per channel (≥1)
- CHANNELS, 4, number of input channels (≥2, need not be a power of two)
- DWELL, 4, clock cycles each channel is held in scan mode (≥1)
- SEL_W (localparam), clog2(CHANNELS), select/channel index width
- CLOCK  input  1  rising-edge clock; the only clock
- RESET  input  1  synchronous, active-high reset
- D  input  CHANNELS*WIDTH  packed channel data; channel i at D[i*WIDTH +: WIDTH]
- MODE  input  1  0 = manual (S selects), 1 = scan (internal round-robin)
- S  input  SEL_W  manual channel select; sampled only when MODE=0
- HOLD  input  1  scan mode only: freezes dwell counter and CH
- Z  output  WIDTH  registered selected data
- CH  output  SEL_W  current channel index (register)
- STROBE  output  1  high for exactly one cycle when CH holds a newly changed value

## Operation
- Reset (RESET=1 at a rising edge):
  - CH=0, dwell counter=0, Z=0, STROBE=0.
  - Reset overrides all other inputs, including mid-scan or mid-dwell.
- Data path, every non-reset edge: Z <= D[CH*WIDTH +: WIDTH], using CH's pre-edge value.
- Manual mode (MODE=0):
  - If S < CHANNELS, then CH <= S. Otherwise the select is out of range; CH is unchanged and STROBE <= 0.
  - STROBE <= (new CH != old CH).
  - Dwell counter forced to 0.
  - HOLD is ignored.
- Scan mode (MODE=1), HOLD=1: counter and CH unchanged; STROBE <= 0.
- Scan mode (MODE=1), HOLD=0, counter < DWELL-1: counter <= counter+1; STROBE <= 0.
- Scan mode (MODE=1), HOLD=0, counter == DWELL-1:
  - counter <= 0.
  - CH <= (CH == CHANNELS-1) ? 0 : CH+1.
  - STROBE <= 1.
- Mode switches:
  - Manual to scan: the scan resumes from the current CH with the counter at 0, so the full DWELL applies to that channel.
  - Scan to manual: takes effect at the next edge; CH <= S (if in range), discarding partial dwell.
- Wrap: CH never takes values ≥ CHANNELS. With non-power-of-two CHANNELS it wraps from CHANNELS-1 to 0.
- DWELL=1: CH advances every unheld cycle; STROBE stays high continuously while advancing.

## Timing
- D/CH to Z latency: 1 cycle. Z after edge k equals the D slice selected by CH before edge k.
- STROBE is registered and coincides with the first cycle of the new CH value.
  - In that cycle Z still shows the previous channel.
  - Z shows the new channel from the following cycle.
- Scan period: CHANNELS*DWELL cycles. Each channel is held for exactly DWELL cycles unless HOLD is applied.
- Reset timeline, MODE=1, HOLD=0, RESET released before edge 1:
  - CH=0 through edge DWELL-1.
  - CH=1 and STROBE=1 after edge DWELL.
  - CH=2 after edge 2*DWELL, and so on.
- HOLD asserted at the edge where the counter would wrap: no advance and no STROBE. The advance occurs at the first edge with HOLD=0.
- Manual select: CH updates 1 cycle after S; Z updates 2 cycles after S.

## Test plan
All scenarios use WIDTH=4, CHANNELS=3, DWELL=2 unless stated.

- Reset: drive garbage on D, S, MODE=1 and HOLD=1, then hold RESET for 2 edges -> Z=0, CH=0, STROBE=0. Assert RESET mid-dwell at CH=2 -> CH=0 and counter=0 at the next edge.
- Scan wrap: D={4'hC,4'hB,4'hA}, MODE=1 after reset -> CH sequence per edge is 0,0,1,1,2,2,0. STROBE=1 exactly on the cycles CH becomes 1, 2 and 0. Z sequence lags one cycle: A,A,B,B,C,C,A.
- Hold: assert HOLD while CH=1 with the counter at 1, for 5 edges -> CH stays 1, STROBE=0, Z=B. After releasing HOLD -> CH=2 at the next edge with STROBE=1.
- Manual select: MODE=0, S=2 then S=2 then S=0 -> CH=2 with STROBE=1, then CH=2 with STROBE=0, then CH=0 with STROBE=1. Z=C one cycle after CH=2.
  - Out of range: S=3 with CHANNELS=3 -> CH unchanged, STROBE=0.
- Mode switch: manual at CH=1, then MODE=1 -> CH holds 1 for the full 2 cycles, then 2. Switching scan to manual with S=0 mid-dwell -> CH=0 next edge, STROBE=1.
- DWELL=1 and CHANNELS=5 (non-power-of-two): CH sequence 0,1,2,3,4,0,1. STROBE is high every cycle. CH never reaches 5–7.
